pipe_wb_regfile: RTL
====================

Name: pipe_wb_regfile

Overview:
Write-back stage and general-purpose register file for the 5-stage pipelined CPU. It sits at the consuming end of the MEM/WB pipeline register.
- Selects the write-back value from the MEM/WB outputs (ALU result or memory output) and commits it to a 32x32 register file.
- Serves the ID stage's two combinational read ports, with same-cycle write-through bypass.
- Keeps a retired-write counter for debug and verification.

Parameters:
NREG, 32, number of architectural registers; r0 hardwired to zero.
DW, 32, data width.
AW, 5, register address width; must satisfy 2^AW = NREG.

Ports:
clock  in  1  single system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset; sampled on posedge clock.
wwreg  in  1  MEM/WB register-write enable.
wm2reg  in  1  MEM/WB select: 1 = memory data, 0 = ALU result.
walu  in  DW  MEM/WB ALU result.
wmo  in  DW  MEM/WB memory output.
wrn  in  AW  MEM/WB destination register number.
rna  in  AW  ID read port A address.
rnb  in  AW  ID read port B address.
qa  out  DW  read data A, combinational.
qb  out  DW  read data B, combinational.
wdi  out  DW  selected write-back data, forwarded to the EX bypass network.
dbg_rn  in  AW  debug read address.
dbg_q  out  DW  debug read data; no bypass, storage value only.
wcount  out  32  count of committed non-r0 writes.

Behaviour:
- Write-back select is combinational: wdi = wm2reg ? wmo : walu. Valid in every cycle regardless of wwreg.
- Commit condition: we = wwreg & (wrn != 0) & ~reset.
- On posedge clock with we = 1, regs[wrn] <= wdi. Write latency is one edge.
- r0:
  - Never written.
  - Always reads 0 on qa, qb and dbg_q, even when wwreg = 1 and wrn = 0.
  - A write to r0 does not increment wcount.
- Read ports qa and qb are combinational:
  - If we = 1 and rna == wrn (nonzero), qa = wdi (write-through bypass). Otherwise qa = regs[rna].
  - qb follows the same rule using rnb.
  - Both ports may address the same register, or the register being written, in the same cycle; both then return wdi.
- dbg_q = regs[dbg_rn] with no bypass, so a newly written value appears one cycle after the commit edge.
- wcount:
  - Increments by 1 on each edge where we = 1.
  - Wraps from 0xFFFFFFFF to 0 with no flag.
- Reset, synchronous and active-high:
  - On a posedge with reset = 1, all registers r1..r31 clear to 0 and wcount clears to 0.
  - A write presented in the same cycle as reset is dropped.
  - While reset = 1, we is forced to 0 and bypass is disabled, so qa and qb show storage values only.
  - After the reset edge, qa, qb, dbg_q and wcount are all 0. wdi tracks its inputs throughout.
- Reset asserted in mid-stream (MEM/WB still holding a valid write): that write is lost. The pipeline is required to flush alongside the register file.
- X-safety: wm2reg and walu/wmo do not affect state when wwreg = 0.
- No stall input: the MEM/WB register presents a fresh entry every cycle, and bubbles arrive as wwreg = 0.

Decomposition:
- Shared package (cpu_pkg):
  - DW and AW constants.
  - The R0 = 5'd0 constant.
  - A wb_sel enum {WB_ALU = 0, WB_MEM = 1} for wm2reg.
- One natural sub-module: regfile_core. It holds the 32xDW storage array, the synchronous write, the synchronous reset clear, and the three read ports.
- The top level adds the write-back mux, the bypass comparators and wcount.

Test Plan:
- Reset, then wwreg = 1, wm2reg = 0, walu = 0x0000_1234, wrn = 5 for one cycle, with rna = 5 in the same cycle -> qa = 0x0000_1234 via bypass before the edge; regs[5] = 0x1234 after the edge; wcount = 1; dbg_rn = 5 gives 0x1234 on the next cycle.
- wm2reg = 1, wmo = 0xDEAD_BEEF, walu = 0x1111_1111, wrn = 7, rna = rnb = 7 -> wdi = qa = qb = 0xDEADBEEF; regs[7] = 0xDEADBEEF after the edge.
- wwreg = 1, wrn = 0, walu = 0xFFFF_FFFF, rna = 0 -> qa = 0 during and after the edge; wcount unchanged.
- Write r3 = 0x55, then in one cycle assert reset together with wwreg = 1, wrn = 3, walu = 0xAA -> after the edge, regs[3] = 0 (the write is dropped) and wcount = 0.
- wwreg = 0, wrn = 9, walu = 0x99, rna = 9 with regs[9] = 0x42 -> qa = 0x42 (no bypass); regs[9] and wcount unchanged.
- Force wcount to 0xFFFF_FFFE via 0xFFFF_FFFE commits (or a bench backdoor), then perform 2 commits -> wcount = 0xFFFF_FFFF, then 0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU pipeline write-back path.
package cpu_pkg;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam logic [AW-1:0] R0 = 5'd0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;
endpackage : cpu_pkg

// File: rtl/pipe_wb_regfile_core.sv
// Register file storage: synchronous write and clear, three combinational reads.
// r0 is never written and is masked to zero on every read port.
module regfile_core
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int DW   = cpu_pkg::DW,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_wrn,
  input  logic [DW-1:0] i_wd,
  input  logic [AW-1:0] i_rna,
  input  logic [AW-1:0] i_rnb,
  input  logic [AW-1:0] i_dbg_rn,
  output logic [DW-1:0] o_qa,
  output logic [DW-1:0] o_qb,
  output logic [DW-1:0] o_dbg_q
);

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wrn != R0)) begin
      r_regs[i_wrn] <= i_wd;
    end
  end

  assign o_qa    = (i_rna    == R0) ? '0 : r_regs[i_rna];
  assign o_qb    = (i_rnb    == R0) ? '0 : r_regs[i_rnb];
  assign o_dbg_q = (i_dbg_rn == R0) ? '0 : r_regs[i_dbg_rn];

endmodule : regfile_core

// File: rtl/pipe_wb_regfile.sv
// Write-back stage: result select, commit into the register file,
// write-through bypass on the ID read ports, and a retired-write counter.
module pipe_wb_regfile
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int DW   = cpu_pkg::DW,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [DW-1:0] walu,
  input  logic [DW-1:0] wmo,
  input  logic [AW-1:0] wrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wdi,
  input  logic [AW-1:0] dbg_rn,
  output logic [DW-1:0] dbg_q,
  output logic [31:0]   wcount
);

  wb_sel_e       w_sel;
  logic          w_we;
  logic [DW-1:0] w_core_qa;
  logic [DW-1:0] w_core_qb;
  logic [31:0]   r_wcount;

  assign w_sel = wb_sel_e'(wm2reg);
  assign wdi   = (w_sel == WB_MEM) ? wmo : walu;

  // Reset suppresses the commit, which also disables the bypass below.
  assign w_we = wwreg && (wrn != R0) && !reset;

  regfile_core #(
    .NREG (NREG),
    .DW   (DW),
    .AW   (AW)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_we),
    .i_wrn    (wrn),
    .i_wd     (wdi),
    .i_rna    (rna),
    .i_rnb    (rnb),
    .i_dbg_rn (dbg_rn),
    .o_qa     (w_core_qa),
    .o_qb     (w_core_qb),
    .o_dbg_q  (dbg_q)
  );

  // w_we already implies wrn != 0, so a matching address is never r0.
  assign qa = (w_we && (rna == wrn)) ? wdi : w_core_qa;
  assign qb = (w_we && (rnb == wrn)) ? wdi : w_core_qb;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wcount <= '0;
    end else if (w_we) begin
      r_wcount <= r_wcount + 32'd1;
    end
  end

  assign wcount = r_wcount;

endmodule : pipe_wb_regfile
